// File: rtl/dmem_pkg.sv
// Shared types and widths for the dmem_responder slice.
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous byte-enabled write, registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);
  // Contents are deliberately never reset; they survive responder resets.
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int k = 0; k < BE_W; k++) begin
          if (i_be[k]) r_mem[i_idx][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, WAIT_CYCLES wait states, held response out.
// Optional macro DMEM_MISALIGN_ERR_EN flags non-word-aligned addresses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [1:0]  o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the responder holds o_rsp_* stable while o_rsp_valid=1 and i_rsp_ready=0.
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
`ifdef DMEM_MISALIGN_ERR_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [BE_W-1:0]    r_be;
  logic               r_rsp_valid;
  logic               r_rsp_err;

  logic               w_cur_we;
  logic [ADDR_W-1:0]  w_cur_addr;
  logic [DATA_W-1:0]  w_cur_wdata;
  logic [BE_W-1:0]    w_cur_be;
  logic               w_oob;
  logic               w_misalign;
  logic               w_err;
  logic               w_accept;
  logic               w_enter_resp;
  logic               w_arr_en;
  logic [DATA_W-1:0]  w_arr_rdata;

  // With zero wait states the array is accessed on the accept edge itself,
  // so it must see the live request rather than the captured copy.
  assign w_cur_we    = (r_state == ST_IDLE) ? i_req_we    : r_we;
  assign w_cur_addr  = (r_state == ST_IDLE) ? i_req_addr  : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? i_req_wdata : r_wdata;
  assign w_cur_be    = (r_state == ST_IDLE) ? i_req_be    : r_be;

  assign w_oob        = |w_cur_addr[ADDR_W-1:IDX_W+2];
  assign w_misalign   = |w_cur_addr[1:0];
  assign w_err        = w_oob | (MISALIGN_EN & w_misalign);
  assign w_accept     = (r_state == ST_IDLE) && i_req_valid;
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));
  assign w_arr_en     = w_enter_resp && !w_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_en    (w_arr_en),
    .i_we    (w_cur_we),
    .i_idx   (w_cur_addr[IDX_W+1:2]),
    .i_wdata (w_cur_wdata),
    .i_be    (w_cur_be),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_be    <= i_req_be;
            if (WAIT_CYCLES == 0) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= ST_RESP;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  // The read register only changes on the RESP-entry edge, so rdata stays stable while held.
  assign o_rsp_rdata = (r_rsp_valid && !r_rsp_err && !r_we) ? w_arr_rdata : '0;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_be;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [1:0]  o_dbg_state;

  logic [32:0] exp_q[$];
  logic [31:0] model [int];
  int n_vec = 0;
  int n_mis = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .i_req_be    (i_req_be),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_dbg_state (o_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: returns {err, rdata} and applies the write to the model.
  function automatic logic [32:0] predict(input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] be);
    logic       err;
    int         idx;
    logic [31:0] word;
    err = (addr >= 32'(DEPTH * 4));
`ifdef DMEM_MISALIGN_ERR_EN
    if (addr[1:0] != 2'b00) err = 1'b1;
`endif
    idx = int'(addr[31:2]);
    if (err) return {1'b1, 32'h0};
    if (we) begin
      word = model.exists(idx) ? model[idx] : 32'h0;
      for (int k = 0; k < 4; k++) if (be[k]) word[8*k +: 8] = wdata[8*k +: 8];
      model[idx] = word;
      return {1'b0, 32'h0};
    end
    return {1'b0, model.exists(idx) ? model[idx] : 32'h0};
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input bit busy_valid);
    logic [32:0] exp;
    int k;
    @(negedge clk);
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    i_req_be    = be;
    exp_q.push_back(predict(we, addr, wdata, be));
    @(posedge clk);
    #1;
    if (busy_valid) begin
      i_req_we    = 1'b1;
      i_req_addr  = 32'h30;
      i_req_wdata = 32'hBAD0BAD0;
      i_req_be    = 4'hF;
    end else begin
      i_req_valid = 1'b0;
    end
    k = 0;
    forever begin
      @(negedge clk);
      if (o_rsp_valid || k > 40) break;
      k++;
    end
    check("latency", 32'(k), 32'(WAITC));
    exp = exp_q.pop_front();
    check("rsp_err", 32'(o_rsp_err), 32'(exp[32]));
    check("rsp_rdata", o_rsp_rdata, exp[31:0]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(o_rsp_valid), 32'd1);
      check("hold_rdata", o_rsp_rdata, exp[31:0]);
      check("hold_err", 32'(o_rsp_err), 32'(exp[32]));
      check("hold_req_ready", 32'(o_req_ready), 32'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b0;
    check("post_hs_valid", 32'(o_rsp_valid), 32'd0);
    check("post_hs_ready", 32'(o_req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "_rdata"}, o_rsp_rdata, 32'd0);
    check({tag, "_err"}, 32'(o_rsp_err), 32'd0);
    check({tag, "_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
    check({tag, "_ready"}, 32'(o_req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    rstn        = 1'b0;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_wdata = '0;
    i_req_be    = '0;
    i_rsp_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    check_reset_outputs("after_reset");

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    do_req(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1, 1'b0);

    do_req(1'b1, 32'h0, 32'h01234567, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h400, 32'h0, 4'hF, 0, 1'b0);
    do_req(1'b1, 32'h400, 32'h55555555, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0);
    do_req(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, 0, 1'b0);

    // Held response with a competing request present; it must not be accepted.
    do_req(1'b1, 32'h30, 32'h30303030, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1);
    do_req(1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0);

    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0);

    // Reset in the middle of WAIT abandons the write.
    do_req(1'b1, 32'h20, 32'h20202020, 4'hF, 0, 1'b0);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_addr  = 32'h20;
    i_req_wdata = 32'hFFFFFFFF;
    i_req_be    = 4'hF;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    check("mid_wait_state", 32'(o_dbg_state), 32'(ST_WAIT));
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_wait_reset");
    @(negedge clk);
    rstn = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0);

    do_req(1'b1, 32'h12, 32'h11223344, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0);

    // Randomised traffic over a small initialised window plus out-of-range hits.
    for (int i = 0; i < 8; i++) do_req(1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h400 + ($urandom_range(0, 1023) << 2);
      else a = 32'h100 + 32'($urandom_range(0, 7) * 4);
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), 1'b0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
